// File: rtl/bpsk_pkg.sv
// Shared BPSK receiver definitions: error-detector modes, default sizing and
// the phase-error word width used by the loop filter and NCO.
package bpsk_pkg;

    typedef enum logic [0:0] {
        ERR_PROD = 1'b0,
        ERR_SIGN = 1'b1
    } err_mode_e;

    localparam int DEF_IN_W     = 16;
    localparam int DEF_DUMP_LEN = 64;
    localparam int DEF_LOCK_N   = 8;
    localparam int PHASE_ERR_W  = 32;

endpackage

// File: rtl/integrate_dump.sv
// One rail of the integrate-and-dump: a sign-extending accumulator whose
// running sum, including the current sample, is captured on the dump strobe.
module integrate_dump #(
    parameter int IN_W  = 16,
    parameter int ACC_W = 22
) (
    input  logic                    clk,
    input  logic                    rst_n,
    input  logic                    clr,
    input  logic                    en,
    input  logic                    dump,
    input  logic signed [IN_W-1:0]  din,
    output logic signed [ACC_W-1:0] dout
);

    logic signed [ACC_W-1:0] acc;
    logic signed [ACC_W-1:0] sum;

    assign sum = acc + ACC_W'(din);

    // NOTE: state registers use non-blocking assignments so every flop samples
    // pre-edge values; blocking here would create order-dependent races.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            acc  <= '0;
            dout <= '0;
        end else if (clr) begin
            acc <= '0;
        end else if (en) begin
            if (dump) begin
                dout <= sum;
                acc  <= '0;
            end else begin
                acc <= sum;
            end
        end
    end

endmodule

// File: rtl/costas_phase_detector.sv
// BPSK Costas phase detector: per-window I/Q means, phase-error word and a
// lock indicator, with a fixed two-cycle latency after the window's last sample.
module costas_phase_detector
    import bpsk_pkg::*;
#(
    parameter int IN_W     = DEF_IN_W,
    parameter int DUMP_LEN = DEF_DUMP_LEN,
    parameter int ERR_MODE = 0,
    parameter int LOCK_N   = DEF_LOCK_N
) (
    input  logic                          clk,
    input  logic                          rst_n,
    input  logic                          sample_valid,
    input  logic signed [IN_W-1:0]        i_in,
    input  logic signed [IN_W-1:0]        q_in,
    input  logic                          clr,
    output logic signed [PHASE_ERR_W-1:0] phase_error,
    output logic                          err_valid,
    output logic signed [IN_W-1:0]        i_mean,
    output logic signed [IN_W-1:0]        q_mean,
    output logic                          locked
);

    localparam int SH     = $clog2(DUMP_LEN);
    localparam int ACC_W  = IN_W + SH;
    localparam int LCNT_W = $clog2(LOCK_N + 1);
    localparam logic [SH-1:0]     CNT_LAST = SH'(DUMP_LEN - 1);
    localparam logic [LCNT_W-1:0] LOCK_MAX = LCNT_W'(LOCK_N);

    logic [SH-1:0]           cnt;
    logic                    accept;
    logic                    dump_now;
    logic signed [ACC_W-1:0] i_dump;
    logic signed [ACC_W-1:0] q_dump;
    logic                    dump_vld;

    logic                    mean_vld;
    logic signed [IN_W-1:0]  i_m;
    logic signed [IN_W-1:0]  q_m;

    logic signed [PHASE_ERR_W-1:0] err_next;
    logic signed [2*IN_W-1:0]      prod;
    logic signed [IN_W:0]          q_ext;
    logic signed [IN_W+1:0]        i_wide;
    logic signed [IN_W+1:0]        q_wide;
    logic [IN_W+1:0]               abs_i;
    logic [IN_W+1:0]               abs_q;
    logic                          good;
    logic [LCNT_W-1:0]             lock_cnt;
    logic [LCNT_W-1:0]             lock_next;
    logic                          unused_lsbs;

    // clr discards any sample presented in the same cycle.
    assign accept   = sample_valid && !clr;
    assign dump_now = accept && (cnt == CNT_LAST);

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            cnt      <= '0;
            dump_vld <= 1'b0;
        end else begin
            dump_vld <= dump_now;
            if (clr)
                cnt <= '0;
            else if (accept)
                cnt <= cnt + 1'b1;
        end
    end

    integrate_dump #(.IN_W(IN_W), .ACC_W(ACC_W)) u_i_rail (
        .clk(clk), .rst_n(rst_n), .clr(clr), .en(accept), .dump(dump_now),
        .din(i_in), .dout(i_dump)
    );

    integrate_dump #(.IN_W(IN_W), .ACC_W(ACC_W)) u_q_rail (
        .clk(clk), .rst_n(rst_n), .clr(clr), .en(accept), .dump(dump_now),
        .din(q_in), .dout(q_dump)
    );

    // Taking the top IN_W bits is the floor-toward-minus-infinity divide;
    // the discarded fraction bits are intentionally dropped.
    assign unused_lsbs = ^{i_dump[SH-1:0], q_dump[SH-1:0]};

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            mean_vld <= 1'b0;
            i_m      <= '0;
            q_m      <= '0;
        end else if (clr) begin
            mean_vld <= 1'b0;
        end else begin
            mean_vld <= dump_vld;
            if (dump_vld) begin
                i_m <= i_dump[ACC_W-1:SH];
                q_m <= q_dump[ACC_W-1:SH];
            end
        end
    end

    // NOTE: every variable gets a default at the top of always_comb so no
    // path leaves it unassigned and no latch is inferred.
    always_comb begin
        prod     = i_m * q_m;
        q_ext    = {q_m[IN_W-1], q_m};
        err_next = PHASE_ERR_W'(prod);
        if (ERR_MODE == int'(ERR_SIGN))
            err_next = i_m[IN_W-1] ? PHASE_ERR_W'(-q_ext) : PHASE_ERR_W'(q_ext);

        i_wide = {{2{i_m[IN_W-1]}}, i_m};
        q_wide = {{2{q_m[IN_W-1]}}, q_m};
        abs_i  = i_wide[IN_W+1] ? -i_wide : i_wide;
        abs_q  = q_wide[IN_W+1] ? -q_wide : q_wide;
        good   = abs_i > (abs_q << 1);

        lock_next = '0;
        if (good)
            lock_next = (lock_cnt == LOCK_MAX) ? lock_cnt : lock_cnt + 1'b1;
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            phase_error <= '0;
            err_valid   <= 1'b0;
            i_mean      <= '0;
            q_mean      <= '0;
            lock_cnt    <= '0;
            locked      <= 1'b0;
        end else if (clr) begin
            err_valid <= 1'b0;
            lock_cnt  <= '0;
            locked    <= 1'b0;
        end else begin
            err_valid <= mean_vld;
            if (mean_vld) begin
                phase_error <= err_next;
                i_mean      <= i_m;
                q_mean      <= q_m;
                lock_cnt    <= lock_next;
                locked      <= (lock_next == LOCK_MAX);
            end
        end
    end

endmodule

// File: tb/tb_costas_phase_detector.sv
// Directed bench for costas_phase_detector: product-mode and sign-mode
// instances share one stimulus stream; expected values are hand-computed.
module tb_costas_phase_detector;

    logic               clk = 1'b0;
    logic               rst_n = 1'b0;
    logic               sample_valid = 1'b0;
    logic signed [15:0] i_in = '0;
    logic signed [15:0] q_in = '0;
    logic               clr = 1'b0;

    logic signed [31:0] perr_p, perr_s;
    logic               ev_p, ev_s;
    logic signed [15:0] i_mean_p, q_mean_p, i_mean_s, q_mean_s;
    logic               locked_p, locked_s;

    int checks = 0;
    int errors = 0;
    int pulses = 0;

    always #5 clk = ~clk;

    always @(posedge clk) if (ev_p) pulses <= pulses + 1;

    costas_phase_detector #(.IN_W(16), .DUMP_LEN(64), .ERR_MODE(0), .LOCK_N(8)) dut_p (
        .clk(clk), .rst_n(rst_n), .sample_valid(sample_valid), .i_in(i_in), .q_in(q_in),
        .clr(clr), .phase_error(perr_p), .err_valid(ev_p), .i_mean(i_mean_p),
        .q_mean(q_mean_p), .locked(locked_p)
    );

    costas_phase_detector #(.IN_W(16), .DUMP_LEN(64), .ERR_MODE(1), .LOCK_N(8)) dut_s (
        .clk(clk), .rst_n(rst_n), .sample_valid(sample_valid), .i_in(i_in), .q_in(q_in),
        .clr(clr), .phase_error(perr_s), .err_valid(ev_s), .i_mean(i_mean_s),
        .q_mean(q_mean_s), .locked(locked_s)
    );

    task automatic idle(input int n);
        repeat (n) begin
            @(posedge clk);
            #1;
        end
    endtask

    // Returns one time step after the edge that accepts the last sample (E0).
    task automatic feed_samples(input int n, input int iv, input int qv,
                                input int last_i, input int gap);
        for (int k = 0; k < n; k++) begin
            if (k > 0) idle(gap);
            sample_valid = 1'b1;
            i_in = 16'((k == n - 1) ? last_i : iv);
            q_in = 16'(qv);
            @(posedge clk);
            #1;
            sample_valid = 1'b0;
        end
    endtask

    task automatic run_window(input string name, input int n, input int iv, input int qv,
                              input int last_i, input int gap, input int ei, input int eq,
                              input int epp, input int eps, input bit elk);
        feed_samples(n, iv, qv, last_i, gap);
        idle(1);
        checks++;
        if (ev_p !== 1'b0) begin
            errors++;
            $display("FAIL %s early_valid: got %0b expected 0", name, ev_p);
        end
        idle(1);
        checks++;
        if (ev_p !== 1'b1 || ev_s !== 1'b1) begin
            errors++;
            $display("FAIL %s err_valid: got %0b/%0b expected 1/1", name, ev_p, ev_s);
        end
        checks++;
        if (i_mean_p !== 16'(ei) || q_mean_p !== 16'(eq)) begin
            errors++;
            $display("FAIL %s means: got %0d/%0d expected %0d/%0d", name, i_mean_p, q_mean_p, ei, eq);
        end
        checks++;
        if (perr_p !== epp) begin
            errors++;
            $display("FAIL %s perr_prod: got %0d expected %0d", name, perr_p, epp);
        end
        checks++;
        if (perr_s !== eps) begin
            errors++;
            $display("FAIL %s perr_sign: got %0d expected %0d", name, perr_s, eps);
        end
        checks++;
        if (locked_p !== elk) begin
            errors++;
            $display("FAIL %s locked: got %0b expected %0b", name, locked_p, elk);
        end
        idle(1);
        checks++;
        if (ev_p !== 1'b0) begin
            errors++;
            $display("FAIL %s pulse_width: got %0b expected 0", name, ev_p);
        end
    endtask

    task automatic lock_up();
        clr = 1'b1;
        idle(1);
        clr = 1'b0;
        for (int k = 0; k < 8; k++)
            run_window("lock_up", 64, 1000, 0, 1000, 0, 1000, 0, 0, 0, k == 7);
    endtask

    task automatic test_reset();
        idle(2);
        checks++;
        if (perr_p !== 0 || ev_p !== 0 || i_mean_p !== 0 || q_mean_p !== 0 || locked_p !== 0) begin
            errors++;
            $display("FAIL reset_state: got perr=%0d ev=%0b i=%0d q=%0d lk=%0b expected all 0",
                     perr_p, ev_p, i_mean_p, q_mean_p, locked_p);
        end
        rst_n = 1'b1;
        idle(1);
    endtask

    task automatic test_constant_lock();
        lock_up();
    endtask

    task automatic test_product_sign();
        run_window("prod", 64, 1000, 500, 1000, 0, 1000, 500, 500000, 500, 1'b0);
        run_window("sign_neg_i", 64, -1000, 500, -1000, 0, -1000, 500, -500000, -500, 1'b0);
        run_window("i_zero_qmin", 64, 0, -32768, 0, 0, 0, -32768, 0, -32768, 1'b0);
        run_window("negate_qmin", 64, -1, -32768, -1, 0, -1, -32768, 32768, 32768, 1'b0);
        run_window("good_neg_i", 64, -1000, 100, -1000, 0, -1000, 100, -100000, -100, 1'b0);
    endtask

    task automatic test_floor();
        run_window("floor_neg", 64, 0, 0, -1, 0, -1, 0, 0, 0, 1'b0);
        run_window("floor_pos", 64, 1, 0, 0, 0, 0, 0, 0, 0, 1'b0);
    endtask

    task automatic test_sparse();
        run_window("sparse", 64, 1000, 500, 1000, 2, 1000, 500, 500000, 500, 1'b0);
    endtask

    task automatic test_clr_mid();
        int p0;
        lock_up();
        p0 = pulses;
        feed_samples(40, 2000, 0, 2000, 0);
        clr = 1'b1;
        sample_valid = 1'b1;
        i_in = 16'sd2000;
        @(posedge clk);
        #1;
        clr = 1'b0;
        sample_valid = 1'b0;
        checks++;
        if (locked_p !== 1'b0) begin
            errors++;
            $display("FAIL clr_mid_locked: got %0b expected 0", locked_p);
        end
        feed_samples(63, 300, 0, 300, 0);
        idle(3);
        checks++;
        if (pulses !== p0) begin
            errors++;
            $display("FAIL clr_mid_early_pulse: got %0d pulses expected %0d", pulses - p0, 0);
        end
        run_window("clr_mid_next", 1, 300, 0, 300, 0, 300, 0, 0, 0, 1'b0);
    endtask

    task automatic test_clr_after_e0();
        int p0;
        lock_up();
        p0 = pulses;
        feed_samples(64, 700, 0, 700, 0);
        clr = 1'b1;
        idle(1);
        clr = 1'b0;
        idle(4);
        checks++;
        if (pulses !== p0 || locked_p !== 1'b0) begin
            errors++;
            $display("FAIL clr_e0_squash: got pulses=%0d locked=%0b expected 0/0", pulses - p0, locked_p);
        end
        checks++;
        if (i_mean_p !== 16'sd1000) begin
            errors++;
            $display("FAIL clr_e0_hold: got i_mean %0d expected 1000", i_mean_p);
        end
        run_window("clr_e0_next", 64, 400, 50, 400, 0, 400, 50, 20000, 50, 1'b0);
    endtask

    task automatic test_lock_hysteresis();
        lock_up();
        feed_samples(64, 100, 100, 100, 0);
        idle(1);
        checks++;
        if (locked_p !== 1'b1) begin
            errors++;
            $display("FAIL hyst_before_e2: got locked %0b expected 1", locked_p);
        end
        idle(1);
        checks++;
        if (locked_p !== 1'b0 || ev_p !== 1'b1 || perr_p !== 10000) begin
            errors++;
            $display("FAIL hyst_at_e2: got locked=%0b ev=%0b perr=%0d expected 0/1/10000",
                     locked_p, ev_p, perr_p);
        end
        idle(1);
    endtask

    task automatic test_async_reset();
        int p0;
        lock_up();
        feed_samples(20, 500, 0, 500, 0);
        #2;
        rst_n = 1'b0;
        #1;
        checks++;
        if (perr_p !== 0 || ev_p !== 0 || i_mean_p !== 0 || q_mean_p !== 0 || locked_p !== 0) begin
            errors++;
            $display("FAIL async_reset: got perr=%0d ev=%0b i=%0d q=%0d lk=%0b expected all 0",
                     perr_p, ev_p, i_mean_p, q_mean_p, locked_p);
        end
        idle(2);
        rst_n = 1'b1;
        idle(1);
        p0 = pulses;
        feed_samples(63, 500, -20, 500, 0);
        idle(3);
        checks++;
        if (pulses !== p0) begin
            errors++;
            $display("FAIL reset_partial_window: got %0d pulses expected 0", pulses - p0);
        end
        run_window("after_reset", 1, 500, -20, 500, 0, 500, -20, -10000, -20, 1'b0);
    endtask

    initial begin
        test_reset();
        test_constant_lock();
        test_product_sign();
        test_floor();
        test_sparse();
        test_clr_mid();
        test_clr_after_e0();
        test_lock_hysteresis();
        test_async_reset();
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
